adaline_neuron: RTL and testbench

- Forward and weight-holding side of the 4-bit Widrow-Hoff learning loop.
- Holds one signed 4-bit weight per pixel and computes the neuron output y as the saturated sum of the weights whose pixel is set.
- Transmits y serially MSB-first under a start strobe: the serial y/start stream that the learning block shifts in.
- Then consumes the returned dw words and applies saturating weight updates.

---
 rtl/adaline_pkg.sv | 37 +++
 rtl/weight_bank.sv | 47 ++++
 rtl/adaline_neuron.sv | 138 +++++++++++++
 tb/tb_adaline_neuron.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adaline_pkg.sv
// Shared types and arithmetic helpers for the ADALINE forward/update datapath.
package adaline_pkg;

    localparam int W_W       = 4;
    localparam int ACC_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SEND,
        UPDATE
    } state_t;

    function automatic logic signed [W_W-1:0] sat_add(
        input logic signed [W_W-1:0] a,
        input logic signed [W_W-1:0] b
    );
        logic signed [W_W:0] s;
        s = {a[W_W-1], a} + {b[W_W-1], b};
        // Overflow shows up as the two top bits disagreeing; the carry bit gives the direction.
        if (s[W_W] != s[W_W-1]) begin
            return s[W_W] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
        end
        return s[W_W-1:0];
    endfunction

    function automatic logic [W_W-1:0] clamp_u(input logic signed [ACC_MAX_W-1:0] a);
        if (a[ACC_MAX_W-1]) begin
            return '0;
        end
        if (a[ACC_MAX_W-2:W_W] != '0) begin
            return '1;
        end
        return a[W_W-1:0];
    endfunction

endpackage

// File: rtl/weight_bank.sv
// Per-pixel signed weight register file: one saturating-add write port, two combinational reads.
module weight_bank
    import adaline_pkg::*;
#(
    parameter int                    N_PIX  = 9,
    parameter int                    W_W    = 4,
    parameter logic signed [W_W-1:0] W_INIT = '0,
    parameter int                    IDX_W  = $clog2(N_PIX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic signed [W_W-1:0]   wr_dw,
    input  logic [IDX_W-1:0]        rd_a_idx,
    output logic signed [W_W-1:0]   rd_a_data,
    input  logic [IDX_W-1:0]        rd_b_idx,
    output logic signed [W_W-1:0]   rd_b_data
);

    logic signed [W_W-1:0] w [N_PIX];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_PIX; i++) begin
                w[IDX_W'(i)] <= W_INIT;
            end
        end else if (wr_en && (int'(wr_idx) < N_PIX)) begin
            w[wr_idx] <= sat_add(w[wr_idx], wr_dw);
        end
    end

    always_comb begin
        rd_a_data = '0;
        if (int'(rd_a_idx) < N_PIX) begin
            rd_a_data = w[rd_a_idx];
        end
    end

    always_comb begin
        rd_b_data = '0;
        if (int'(rd_b_idx) < N_PIX) begin
            rd_b_data = w[rd_b_idx];
        end
    end

endmodule

// File: rtl/adaline_neuron.sv
// ADALINE neuron: accumulates masked weights, streams the clamped output MSB-first,
// then applies the returned per-pixel deltas with saturation.
module adaline_neuron
    import adaline_pkg::*;
#(
    parameter int                    N_PIX  = 9,
    parameter int                    W_W    = 4,
    parameter logic signed [W_W-1:0] W_INIT = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [N_PIX-1:0]           pix_vec,
    input  logic                       learn_en,
    output logic                       y_ser,
    output logic                       y_start,
    input  logic                       dw_valid,
    input  logic signed [W_W-1:0]      dw,
    output logic                       busy,
    input  logic [$clog2(N_PIX)-1:0]   w_rd_idx,
    output logic signed [W_W-1:0]      w_rd_data
);

    localparam int IDX_W = $clog2(N_PIX);
    localparam int ACC_W = W_W + $clog2(N_PIX + 1);
    localparam int K_W   = $clog2(W_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(W_W - 1);

    state_t state, state_next;

    logic [N_PIX-1:0]        pix_reg;
    logic                    learn_reg;
    logic signed [ACC_W-1:0] acc, acc_next, term;
    logic [IDX_W-1:0]        idx;
    logic [K_W-1:0]          k;
    logic [W_W-1:0]          y_sat;
    logic signed [W_W-1:0]   w_acc;
    logic                    wr_en;

    assign frame_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    // idx doubles as the update index, so the write port and ACCUM read share it.
    assign wr_en       = (state == UPDATE) && dw_valid && pix_reg[idx];

    weight_bank #(
        .N_PIX  (N_PIX),
        .W_W    (W_W),
        .W_INIT (W_INIT),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (idx),
        .wr_dw     (dw),
        .rd_a_idx  (idx),
        .rd_a_data (w_acc),
        .rd_b_idx  (w_rd_idx),
        .rd_b_data (w_rd_data)
    );

    always_comb begin
        term = '0;
        if (pix_reg[idx]) begin
            term = ACC_W'(w_acc);
        end
        acc_next = acc + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (frame_valid) state_next = ACCUM;
            ACCUM:  if (idx == LAST_IDX) state_next = SEND;
            SEND:   if (k == LAST_K) state_next = learn_reg ? UPDATE : IDLE;
            UPDATE: if (dw_valid && idx == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_reg   <= '0;
            learn_reg <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            k         <= '0;
            y_sat     <= '0;
            y_ser     <= 1'b0;
            y_start   <= 1'b0;
        end else begin
            y_ser   <= 1'b0;
            y_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        pix_reg   <= pix_vec;
                        learn_reg <= learn_en;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        y_sat <= clamp_u(ACC_MAX_W'(acc_next));
                        k     <= '0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SEND: begin
                    y_start <= 1'b1;
                    y_ser   <= y_sat[LAST_K - k];
                    k       <= k + 1'b1;
                end
                UPDATE: begin
                    if (dw_valid) begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adaline_neuron.sv
// Directed bench for adaline_neuron: table of frames/updates plus hand-written corner sequences.
module tb_adaline_neuron;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_valid;
    logic              frame_ready;
    logic [8:0]        pix_vec;
    logic              learn_en;
    logic              y_ser;
    logic              y_start;
    logic              dw_valid;
    logic signed [3:0] dw;
    logic              busy;
    logic [3:0]        w_rd_idx;
    logic signed [3:0] w_rd_data;

    int checks   = 0;
    int failures = 0;
    int mw [9];

    typedef struct {
        logic [8:0]        pix;
        logic              learn;
        logic signed [3:0] dwv;
        logic [3:0]        exp_y;
        int                exp_w0;
    } vec_t;

    vec_t tbl [10];

    adaline_neuron #(
        .N_PIX  (9),
        .W_W    (4),
        .W_INIT (4'sd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .pix_vec     (pix_vec),
        .learn_en    (learn_en),
        .y_ser       (y_ser),
        .y_start     (y_start),
        .dw_valid    (dw_valid),
        .dw          (dw),
        .busy        (busy),
        .w_rd_idx    (w_rd_idx),
        .w_rd_data   (w_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_weights(input string tag);
        for (int i = 0; i < 16; i++) begin
            w_rd_idx = 4'(i);
            #1;
            chk($sformatf("%s_w%0d", tag, i), int'(w_rd_data), (i < 9) ? mw[i] : 0);
        end
        w_rd_idx = '0;
    endtask

    // Drives one frame and checks the serial output window; leaves DUT in UPDATE when learn=1.
    task automatic run_frame(input logic [8:0] pix, input logic learn, input logic [3:0] exp_y,
                             input bit noise, input string tag);
        chk({tag, "_ready_pre"}, int'(frame_ready), 1);
        frame_valid = 1'b1;
        pix_vec     = pix;
        learn_en    = learn;
        tick();
        frame_valid = 1'b0;
        pix_vec     = ~pix;
        learn_en    = ~learn;
        chk({tag, "_busy_acc"}, int'(busy), 1);
        chk({tag, "_ready_acc"}, int'(frame_ready), 0);
        for (int c = 1; c <= 13; c++) begin
            if (noise && c == 10) begin
                frame_valid = 1'b1;
                pix_vec     = 9'h1FF;
                learn_en    = 1'b1;
            end
            if (noise && c == 12) frame_valid = 1'b0;
            tick();
            if (c >= 10) begin
                chk($sformatf("%s_ystart_c%0d", tag, c), int'(y_start), 1);
                chk($sformatf("%s_yser_c%0d", tag, c), int'(y_ser), int'(exp_y[13 - c]));
            end else begin
                chk($sformatf("%s_ystart_c%0d", tag, c), int'(y_start), 0);
            end
        end
        learn_en = 1'b0;
        tick();
        chk({tag, "_ystart_end"}, int'(y_start), 0);
        chk({tag, "_yser_end"}, int'(y_ser), 0);
        chk({tag, "_busy_end"}, int'(busy), int'(learn));
    endtask

    // Feeds nine dw words; with gaps, idle cycles carry junk dw that must be ignored.
    task automatic send_dw(input logic [8:0] pix, input logic signed [3:0] v, input bit gaps,
                           input string tag);
        int s;
        for (int i = 0; i < 9; i++) begin
            dw_valid = 1'b1;
            dw       = v;
            tick();
            if (pix[i]) begin
                s = mw[i] + int'(v);
                mw[i] = (s > 7) ? 7 : ((s < -8) ? -8 : s);
            end
            if (gaps && i < 8) begin
                dw_valid = 1'b0;
                dw       = 4'sd7;
                tick();
                tick();
                chk($sformatf("%s_gapbusy%0d", tag, i), int'(busy), 1);
            end
        end
        dw_valid = 1'b0;
        dw       = '0;
        chk({tag, "_busy_done"}, int'(busy), 0);
        chk({tag, "_ready_done"}, int'(frame_ready), 1);
    endtask

    initial begin
        tbl[0] = '{9'h1FF, 1'b0, 4'sd0,  4'd0,  0};
        tbl[1] = '{9'h1FF, 1'b1, 4'sd2,  4'd0,  2};
        tbl[2] = '{9'h007, 1'b0, 4'sd0,  4'd6,  2};
        tbl[3] = '{9'h1FF, 1'b0, 4'sd0,  4'd15, 2};
        tbl[4] = '{9'h001, 1'b1, 4'sd7,  4'd2,  7};
        tbl[5] = '{9'h001, 1'b1, 4'sd7,  4'd7,  7};
        tbl[6] = '{9'h001, 1'b1, -4'sd8, 4'd7, -1};
        tbl[7] = '{9'h001, 1'b1, -4'sd8, 4'd0, -8};
        tbl[8] = '{9'h001, 1'b0, 4'sd0,  4'd0, -8};
        tbl[9] = '{9'h0AA, 1'b1, 4'sd3,  4'd8, -8};

        for (int i = 0; i < 9; i++) mw[i] = 0;
        rst         = 1'b1;
        frame_valid = 1'b0;
        pix_vec     = '0;
        learn_en    = 1'b0;
        dw_valid    = 1'b0;
        dw          = '0;
        w_rd_idx    = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ystart", int'(y_start), 0);
        chk("rst_yser", int'(y_ser), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(frame_ready), 1);
        check_weights("rst");

        for (int r = 0; r < 10; r++) begin
            run_frame(tbl[r].pix, tbl[r].learn, tbl[r].exp_y, 1'b0, $sformatf("row%0d", r));
            if (tbl[r].learn) send_dw(tbl[r].pix, tbl[r].dwv, 1'b0, $sformatf("row%0d", r));
            w_rd_idx = '0;
            #1;
            chk($sformatf("row%0d_w0", r), int'(w_rd_data), tbl[r].exp_w0);
        end
        check_weights("mask");

        // frame_valid during SEND, then dw_valid while idle: neither may take effect.
        run_frame(9'h000, 1'b0, 4'd0, 1'b1, "noise");
        tick();
        chk("noise_busy_after", int'(busy), 0);
        dw_valid = 1'b1;
        dw       = 4'sd7;
        repeat (3) tick();
        dw_valid = 1'b0;
        chk("idle_dw_busy", int'(busy), 0);
        check_weights("idle_dw");

        // Weights now sum to 20 over all pixels -> clamps to 15; then gapped updates.
        run_frame(9'h1FF, 1'b1, 4'd15, 1'b0, "gap");
        send_dw(9'h1FF, -4'sd1, 1'b1, "gap");
        check_weights("gap");

        // Reset landing in the second SEND cycle.
        frame_valid = 1'b1;
        pix_vec     = 9'h1FF;
        learn_en    = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (11) tick();
        chk("midrst_ystart_pre", int'(y_start), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ystart", int'(y_start), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(frame_ready), 1);
        for (int i = 0; i < 9; i++) mw[i] = 0;
        check_weights("midrst");
        run_frame(9'h1FF, 1'b0, 4'd0, 1'b0, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
